// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the integer execution units.
// Holds the add/subtract opcode type, the default geometry of the pipelined
// adder and the signed-overflow rule used at the last pipeline stage.
package arith_pkg;

  // Opcode carried by in_sub: 0 adds, 1 subtracts.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } add_op_e;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;
  localparam int unsigned DEF_TAG_W  = 6;

  // Two's-complement overflow: operands agree in sign but the sum does not.
  // b_msb is the sign of the prepared operand (already inverted for a subtract).
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

  // Second operand after preparation: inverted for a subtract so that the
  // carry-in of 1 completes the two's-complement negation.
  function automatic logic prep_b_bit(input add_op_e op, input logic b_bit);
    return (op == OP_SUB) ? ~b_bit : b_bit;
  endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// Handshake bundle of the pipelined adder/subtractor.
// Request side : in_valid/in_ready, operands in_a/in_b, in_sub, in_tag.
// Response side: out_valid/out_ready, out_sum, out_cout, out_ovf, out_tag.
// master = issuing/consuming unit, slave = the arithmetic block.
interface pipelined_add_sub_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 6
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );

endinterface

// File: rtl/pipelined_add_sub_chunk_adder.sv
// Combinational CHUNK-bit adder used for one slice of the pipelined adder.
// Ports: a, b  - operand slices
//        cin   - carry into the slice
//        sum   - slice sum
//        cout  - carry out of the slice
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] w_total;

  // One extra bit captures the carry leaving the slice.
  assign w_total = {1'b0, a} + {1'b0, b} + (CHUNK + 1)'(cin);
  assign sum     = w_total[CHUNK-1:0];
  assign cout    = w_total[CHUNK];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor.
// A WIDTH-bit operation is split into STAGES slices of CHUNK bits; stage k
// resolves slice k and hands its carry to stage k+1 through a register, so
// no full-width carry chain exists. Latency is STAGES cycles, throughput one
// operation per cycle. Backpressure propagates combinationally from out_ready
// to in_ready so bubbles collapse.
// Ports: clk   - rising-edge clock
//        rst_n - asynchronous active-low reset (clears valids and data)
//        flush - synchronous squash of everything in flight
//        bus   - slave side of pipelined_add_sub_if (request + response)
module pipelined_add_sub
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned TAG_W  = DEF_TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  pipelined_add_sub_if.slave  bus
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  // Geometry must divide evenly; reject bad builds at elaboration.
  if ((STAGES == 0) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH must be a non-zero multiple of STAGES");
  end

  // Per-stage valid bits and the backpressure chain.
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_ready;
  logic [STAGES-1:0] w_en;

  // Registered per-stage payload, exported from each stage for the next.
  logic [WIDTH-1:0] w_a   [STAGES];
  logic [WIDTH-1:0] w_b   [STAGES];
  logic [WIDTH-1:0] w_sum [STAGES];
  logic             w_c   [STAGES];
  logic [TAG_W-1:0] w_tag [STAGES];
  logic             w_ovf;

  // Operand preparation at acceptance.
  add_op_e          w_op;
  logic [WIDTH-1:0] w_b_prep;
  logic             w_c0;

  assign w_op = add_op_e'(bus.in_sub);
  assign w_c0 = (w_op == OP_SUB);

  always_comb begin
    w_b_prep = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_b_prep[i] = prep_b_bit(w_op, bus.in_b[i]);
    end
  end

  // ready[k]: the slot after stage k frees up this cycle. Walks from the
  // output back towards the input in a single block.
  always_comb begin
    w_ready             = '0;
    w_ready[STAGES-1]   = bus.out_ready;
    for (int unsigned i = 1; i < STAGES; i++) begin
      w_ready[STAGES-1-i] = !r_valid[STAGES-i] || w_ready[STAGES-i];
    end
  end

  // A stage may load when it is empty or its content moves on.
  assign w_en = ~r_valid | w_ready;

  // Valid bits: flush wins over any same-cycle acceptance or output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      if (w_en[0]) begin
        r_valid[0] <= bus.in_valid;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (w_en[k]) begin
          r_valid[k] <= r_valid[k-1];
        end
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LSB = k * CHUNK;

    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_sum_in;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_cin;
    logic             w_vin;
    logic [TAG_W-1:0] w_tag_in;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic [TAG_W-1:0] r_tag;

    // Stage 0 takes the freshly prepared request; later stages take the
    // registers of the stage before them.
    if (k == 0) begin : g_head
      assign w_a_in   = bus.in_a;
      assign w_b_in   = w_b_prep;
      assign w_cin    = w_c0;
      assign w_sum_in = '0;
      assign w_tag_in = bus.in_tag;
      assign w_vin    = bus.in_valid;
    end else begin : g_body
      assign w_a_in   = w_a[k-1];
      assign w_b_in   = w_b[k-1];
      assign w_cin    = w_c[k-1];
      assign w_sum_in = w_sum[k-1];
      assign w_tag_in = w_tag[k-1];
      assign w_vin    = r_valid[k-1];
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
      .a    (w_a_in[LSB +: CHUNK]),
      .b    (w_b_in[LSB +: CHUNK]),
      .cin  (w_cin),
      .sum  (w_chunk_sum),
      .cout (w_chunk_cout)
    );

    // Insert this stage's slice into the partial sum built so far.
    always_comb begin
      w_sum_nxt                = w_sum_in;
      w_sum_nxt[LSB +: CHUNK]  = w_chunk_sum;
    end

    // Data only moves with a valid operation, so a stalled result holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a   <= '0;
        r_b   <= '0;
        r_sum <= '0;
        r_c   <= 1'b0;
        r_tag <= '0;
      end else if (w_en[k] && w_vin) begin
        r_a   <= w_a_in;
        r_b   <= w_b_in;
        r_sum <= w_sum_nxt;
        r_c   <= w_chunk_cout;
        r_tag <= w_tag_in;
      end
    end

    assign w_a[k]   = r_a;
    assign w_b[k]   = r_b;
    assign w_sum[k] = r_sum;
    assign w_c[k]   = r_c;
    assign w_tag[k] = r_tag;

    // The last stage also completes the sign bit, so overflow is known here.
    if (k == STAGES - 1) begin : g_tail
      logic r_ovf;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_en[k] && w_vin) begin
          r_ovf <= signed_ovf(w_a_in[WIDTH-1], w_b_in[WIDTH-1],
                              w_sum_nxt[WIDTH-1]);
        end
      end

      assign w_ovf = r_ovf;
    end
  end

  assign bus.in_ready  = w_en[0];
  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.out_sum   = w_sum[STAGES-1];
  assign bus.out_cout  = w_c[STAGES-1];
  assign bus.out_ovf   = w_ovf;
  assign bus.out_tag   = w_tag[STAGES-1];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (32-bit, 4 stages, plus a
// single-stage build). Results are predicted with signed/unsigned integer
// arithmetic and kept in an in-order scoreboard.
module tb_pipelined_add_sub;
  import arith_pkg::*;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;
  localparam int unsigned TAG_W  = 6;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic flush  = 1'b0;
  logic flush1 = 1'b0;

  int   n_checks    = 0;
  int   n_errors    = 0;
  int   n_delivered = 0;
  res_t sb_q[$];

  always #5 clk = ~clk;

  pipelined_add_sub_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus  ();
  pipelined_add_sub_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus1 ();

  pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(1), .TAG_W(TAG_W)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush1),
    .bus   (bus1.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on the operands as numbers.
  function automatic res_t model(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic sub,
                                 input logic [TAG_W-1:0] tag);
    res_t   r;
    longint sa, sb, s;
    sa     = longint'($signed(a));
    sb     = longint'($signed(b));
    s      = sub ? (sa - sb) : (sa + sb);
    r.sum  = WIDTH'(s);
    r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r.cout = sub ? (a >= b)
                 : ((longint'(a) + longint'(b)) > 64'sd4294967295);
    r.tag  = tag;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Scoreboard monitor, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      check_eq("in_ready", 64'(bus.in_ready),
               64'(!((sb_q.size() == int'(STAGES)) && !bus.out_ready)));
      if (flush) begin
        sb_q.delete();
      end else begin
        if (bus.out_valid) begin
          if (sb_q.size() == 0) begin
            check_eq("spurious_out", 64'(bus.out_valid), 64'(0));
          end else begin
            check_eq("result",
                     64'({bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_tag}),
                     64'(sb_q[0]));
            if (bus.out_ready) begin
              void'(sb_q.pop_front());
              n_delivered++;
            end
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          sb_q.push_back(model(bus.in_a, bus.in_b, bus.in_sub, bus.in_tag));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic [TAG_W-1:0] tag);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
  endtask

  // One operation into an idle pipe; checks latency and the flag values.
  task automatic run_single(input string name,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sub, input logic [TAG_W-1:0] tag,
                            input logic [WIDTH-1:0] esum,
                            input logic ecout, input logic eovf);
    int lat;
    int guard;
    bus.out_ready = 1'b1;
    drive_op(a, b, sub, tag);
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      step();
      guard++;
    end
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq({name, "_latency"}, 64'(lat), 64'(STAGES));
    check_eq({name, "_sum"}, 64'(bus.out_sum), 64'(esum));
    check_eq({name, "_flags"}, 64'({bus.out_cout, bus.out_ovf}),
             64'({ecout, eovf}));
    check_eq({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, stall, cyc, d0, accepted, guard;
    logic saw_full;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_a      = '0;
    bus1.in_b      = '0;
    bus1.in_sub    = 1'b0;
    bus1.in_tag    = '0;
    bus1.out_ready = 1'b1;

    // Reset state.
    @(posedge clk);
    step();
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check_eq("rst_out_data",
             64'({bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_tag}), 64'(0));
    rst_n = 1'b1;
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Directed arithmetic corners.
    run_single("add_carry", 32'hFFFF_FFFF, 32'h1, 1'b0, 6'd1,
               32'h0000_0000, 1'b1, 1'b0);
    run_single("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 6'd2,
               32'h8000_0000, 1'b0, 1'b1);
    run_single("sub_borrow", 32'd5, 32'd7, 1'b1, 6'd3,
               32'hFFFF_FFFE, 1'b0, 1'b0);
    run_single("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 6'd4,
               32'h7FFF_FFFF, 1'b1, 1'b1);
    step();

    // Back-pressure: 8 back-to-back ops, 3-cycle stall once results begin.
    d0       = n_delivered;
    idx      = 0;
    stall    = -1;
    cyc      = 0;
    saw_full = 1'b0;
    while ((idx < 8 || sb_q.size() != 0) && cyc < 100) begin
      if (bus.out_valid && stall < 0) stall = 3;
      bus.out_ready = !(stall > 0);
      if (idx < 8) drive_op(pick(), pick(), 1'($urandom_range(0, 1)), 6'(idx));
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (!bus.in_ready) saw_full = 1'b1;
      if (bus.in_valid && bus.in_ready) idx++;
      if (stall > 0) stall--;
      step();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("bp_full_stall", 64'(saw_full), 64'(1));
    check_eq("bp_delivered", 64'(n_delivered - d0), 64'(8));

    // Flush with three in flight and a same-cycle offer.
    for (int i = 0; i < 3; i++) begin
      drive_op(pick(), pick(), 1'($urandom_range(0, 1)), 6'(20 + i));
      step();
    end
    drive_op(pick(), pick(), 1'b0, 6'd23);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_cleared", 64'(bus.out_valid), 64'(0));
    run_single("post_flush", 32'd100, 32'd58, 1'b1, 6'd24,
               32'd42, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq("flush_quiet", 64'(bus.out_valid), 64'(0));
      step();
    end

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 7)
        drive_op(pick(), pick(), 1'($urandom_range(0, 1)), 6'(c));
      else
        bus.in_valid = 1'b0;
      flush = ($urandom_range(0, 49) == 0);
      step();
    end
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      step();
      guard++;
    end
    check_eq("drain_empty", 64'(sb_q.size()), 64'(0));
    step();
    check_eq("drain_idle", 64'(bus.out_valid), 64'(0));

    // Asynchronous reset with a full, stalled pipe.
    bus.out_ready = 1'b0;
    accepted = 0;
    guard    = 0;
    while (accepted < int'(STAGES) && guard < 20) begin
      drive_op(32'(10 + accepted), 32'd20, 1'b0, 6'(40 + accepted));
      @(negedge clk);
      if (bus.in_ready) accepted++;
      step();
      guard++;
    end
    bus.in_valid = 1'b0;
    check_eq("full_out_valid", 64'(bus.out_valid), 64'(1));
    check_eq("full_in_ready", 64'(bus.in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(bus.out_valid), 64'(0));
    check_eq("async_rst_sum", 64'(bus.out_sum), 64'(0));
    check_eq("async_rst_flags",
             64'({bus.out_cout, bus.out_ovf, bus.out_tag}), 64'(0));
    check_eq("async_rst_valid1", 64'(bus1.out_valid), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_single("after_reset", 32'd3, 32'd4, 1'b0, 6'd7, 32'd7, 1'b0, 1'b0);

    // Single-stage build returns after one edge.
    bus1.in_a     = 32'd3;
    bus1.in_b     = 32'd4;
    bus1.in_sub   = 1'b0;
    bus1.in_tag   = 6'd9;
    bus1.in_valid = 1'b1;
    check_eq("s1_in_ready", 64'(bus1.in_ready), 64'(1));
    step();
    bus1.in_valid = 1'b0;
    check_eq("s1_out_valid", 64'(bus1.out_valid), 64'(1));
    check_eq("s1_sum", 64'(bus1.out_sum), 64'(7));
    check_eq("s1_tag", 64'(bus1.out_tag), 64'(9));
    step();
    check_eq("s1_idle", 64'(bus1.out_valid), 64'(0));

    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

- Parametrised, pipelined two's-complement adder/subtractor for the integer execution units of the out-of-order core.
- Splits a WIDTH-bit add or subtract into STAGES equal chunks and resolves one chunk per cycle. The carry moves between pipeline registers.
- Returns the sum with carry-out, signed overflow and the issuing instruction's tag.
- Valid/ready handshakes on both sides; flush port for squashing on mispredict.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of STAGES.
- STAGES, 4: pipeline depth, which is also the latency in cycles. Chunk width CHUNK = WIDTH/STAGES. STAGES=1 is legal and gives a single-register adder.
- TAG_W, 6: width of the opaque tag carried with each operation.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of every in-flight operation.
- in_valid  in  1  operation offered.
- in_ready  out  1  block accepts the offered operation this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A−B.
- in_tag  in  TAG_W  tag returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of bit WIDTH−1. For subtract, 1 means no borrow.
- out_ovf  out  1  signed overflow.
- out_tag  out  TAG_W  tag of the result.

## Operation
- **Acceptance:** an operation is accepted on a rising edge where in_valid && in_ready && !flush.
- **Operand preparation at acceptance:**
  - b' = in_sub ? ~in_b : in_b
  - carry-in c0 = in_sub
- **Per-stage arithmetic:** stage k (0..STAGES−1) adds bits [k·CHUNK +: CHUNK] of A and b' plus the carry registered by stage k−1 (c0 for stage 0).
  - Stage k registers its chunk sum, its carry-out, the lower sum chunks already computed, and the upper operand chunks still needed.
  - No full-width carry chain exists anywhere.
- **Flags from the last stage:**
  - out_cout = carry out of the top chunk.
  - out_ovf = (A[W−1] == b'[W−1]) && (sum[W−1] != A[W−1]).
  - A[W−1] and b'[W−1] travel with the operation.
- **Stall and ready rules:**
  - Each stage has a valid bit; stage k advances when !valid[k+1] || ready[k+1].
  - Last stage: ready = out_ready.
  - in_ready = !valid[0] || ready[0]. This is a combinational path from out_ready to in_ready; bubbles collapse.
- **Output stability:** while out_valid && !out_ready, out_sum, out_cout, out_ovf and out_tag hold stable.
- **Ordering:** results emerge in acceptance order. Nothing is dropped or duplicated.
- **Flush:**
  - Clears every valid bit on the next edge.
  - Takes priority over a same-cycle acceptance (that operation is discarded) and over a same-cycle output transfer.
  - Data registers need not clear.
- **Reset (rst_n low):**
  - All valid bits and all data registers go to 0 immediately, without waiting for a clock edge.
  - Hence out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_tag=0.
  - in_ready=1 while rst_n is high after reset, since the pipe is empty.
  - Reset mid-operation discards all in-flight work.

## Timing
- **Latency:** an operation accepted at edge t presents out_valid=1 from edge t+STAGES−1, i.e. after STAGES rising edges including the accepting one. This holds when the pipe is unstalled.
- **Throughput:** one operation per cycle with out_ready held high.
- **Full pipe:** all STAGES valid with out_ready=0 gives in_ready=0 in that same cycle.
- **Simultaneous events:** with a full pipe, out_ready=1 and in_valid=1, the output transfers and a new operation is accepted on the same edge.
- **After flush:** the first acceptance can occur on the edge after flush drops. Its full STAGES latency applies.

## Structure
- Shared package arith_pkg holds add_op_e {OP_ADD=0, OP_SUB=1}. in_sub is cast to this type.
- CHUNK is a localparam derived inside the module.
- One sub-module, chunk_adder: a combinational CHUNK-bit ripple adder with inputs a, b, cin and outputs sum, cout. It is instantiated once per stage in a generate loop.
- Elaboration-time assertion: WIDTH % STAGES == 0.

## Test plan
All scenarios use WIDTH=32, STAGES=4 unless stated.
1. **Add with carry, no overflow:** add 0xFFFF_FFFF + 0x1 → out_sum=0x0000_0000, out_cout=1, out_ovf=0; out_valid appears 4 edges after acceptance.
2. **Add with signed overflow:** add 0x7FFF_FFFF + 0x1 → out_sum=0x8000_0000, out_cout=0, out_ovf=1.
3. **Subtract, both flag outcomes:**
   - sub 5 − 7 → out_sum=0xFFFF_FFFE, out_cout=0, out_ovf=0.
   - sub 0x8000_0000 − 1 → out_sum=0x7FFF_FFFF, out_cout=1, out_ovf=1.
4. **Back-pressure:** 8 back-to-back operations with tags 0..7; out_ready=0 for 3 cycles once results begin → in_ready drops when all 4 stages are full. Results stay stable while stalled and emerge in tag order 0..7 with correct sums.
5. **Flush:** 3 operations in flight; flush=1 with in_valid=1 in the same cycle → none of the 4 operations ever produces out_valid. The next operation after flush returns after 4 edges.
6. **Asynchronous reset mid-operation:** rst_n driven low between clock edges with a full pipe → out_valid and out_sum read 0 before the next edge. After release, a single add 3+4 returns 7 at normal latency; a STAGES=1 build returns the same result after 1 edge.
